// File: rtl/circular_buffer_pkg.sv
// Shared types and helpers for the multi-channel circular buffer.
// Default geometry: 8 entries of 8 bits per channel, 4 channels.
package circular_buffer_pkg;

    localparam int NSIZE     = 3;
    localparam int NWIDTH    = 8;
    localparam int NCHANNELS = 4;
    localparam int CWIDTH    = (NCHANNELS > 1) ? $clog2(NCHANNELS) : 1;
    localparam int DEPTH     = 1 << NSIZE;

    typedef logic [NSIZE-1:0]  ptr_t;
    typedef logic [NSIZE:0]    cnt_t;
    typedef logic [CWIDTH-1:0] ch_t;

    function automatic logic is_full(cnt_t c);
        return c == cnt_t'(DEPTH);
    endfunction

    function automatic logic is_empty(cnt_t c);
        return c == '0;
    endfunction

endpackage

// File: rtl/circular_buffer_ring.sv
// Pointer and occupancy bookkeeping for one channel of the buffer.
// Pointers wrap naturally; the count disambiguates full from empty.
module circular_buffer_ring
    import circular_buffer_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic inc_wr,
    input  logic inc_rd,
    input  logic clr,
    output ptr_t rd,
    output ptr_t wr,
    output cnt_t count,
    output logic full,
    output logic empty
);

    always_ff @(posedge clock) begin
        if (!reset_n || clr) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            wr    <= wr + ptr_t'(inc_wr);
            rd    <= rd + ptr_t'(inc_rd);
            count <= count + cnt_t'(inc_wr) - cnt_t'(inc_rd);
        end
    end

    assign full  = is_full(count);
    assign empty = is_empty(count);

endmodule

// File: rtl/circular_buffer_mc.sv
// Multi-channel circular FIFO: one push, one pop and one clear per cycle.
// Define CIRCULAR_BUFFER_MC_ERR_EN to add sticky overflow/underflow flags.
module circular_buffer_mc
    import circular_buffer_pkg::*;
#(
    parameter  int NSize     = NSIZE,
    parameter  int NWidth    = NWIDTH,
    parameter  int NChannels = NCHANNELS,
    localparam int CW        = (NChannels > 1) ? $clog2(NChannels) : 1,
    localparam int D         = 1 << NSize,
    localparam int CNTW      = NSize + 1
)(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clear_en,
    input  logic [CW-1:0]             clear_ch,
    input  logic                      push_en,
    input  logic [CW-1:0]             push_ch,
    input  logic [NWidth-1:0]         push_data,
    output logic                      push_ok,
    input  logic                      pop_en,
    input  logic [CW-1:0]             pop_ch,
    output logic                      pop_ok,
    output logic [NWidth-1:0]         out_data,
    output logic                      out_valid,
    output logic [CW-1:0]             out_ch,
    output logic [NChannels*CNTW-1:0] count,
    output logic [NChannels*CNTW-1:0] space
`ifdef CIRCULAR_BUFFER_MC_ERR_EN
    ,
    output logic [NChannels-1:0]      overflow,
    output logic [NChannels-1:0]      underflow
`endif
);

    ptr_t rd  [NChannels];
    ptr_t wr  [NChannels];
    cnt_t cnt [NChannels];

    logic [NChannels-1:0] full;
    logic [NChannels-1:0] empty;
    logic [NChannels-1:0] clr_hit;
    logic [NChannels-1:0] push_sel;
    logic [NChannels-1:0] pop_sel;
    logic [NChannels-1:0] inc_wr;
    logic [NChannels-1:0] inc_rd;

    logic [NWidth-1:0] mem [NChannels][D];

    ptr_t wr_sel;
    ptr_t rd_sel;

    // One-hot channel decode; out-of-range indices match nothing.
    always_comb begin
        clr_hit  = '0;
        push_sel = '0;
        pop_sel  = '0;
        wr_sel   = '0;
        rd_sel   = '0;
        for (int c = 0; c < NChannels; c++) begin
            clr_hit[c]  = clear_en && (clear_ch == CW'(c));
            push_sel[c] = push_en && (push_ch == CW'(c));
            pop_sel[c]  = pop_en && (pop_ch == CW'(c));
            if (push_sel[c]) wr_sel = wr[c];
            if (pop_sel[c])  rd_sel = rd[c];
        end
    end

    assign inc_wr  = push_sel & ~full & ~clr_hit;
    assign inc_rd  = pop_sel & ~empty & ~clr_hit;
    assign push_ok = |inc_wr;
    assign pop_ok  = |inc_rd;

    for (genvar c = 0; c < NChannels; c++) begin : g_ch
        circular_buffer_ring u_ring (
            .clock   (clock),
            .reset_n (reset_n),
            .inc_wr  (inc_wr[c]),
            .inc_rd  (inc_rd[c]),
            .clr     (clr_hit[c]),
            .rd      (rd[c]),
            .wr      (wr[c]),
            .count   (cnt[c]),
            .full    (full[c]),
            .empty   (empty[c])
        );
        assign count[c*CNTW +: CNTW] = cnt[c];
        assign space[c*CNTW +: CNTW] = cnt_t'(D) - cnt[c];
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (push_ok) mem[push_ch][wr_sel] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            out_valid <= pop_ok;
            if (pop_ok) begin
                out_data <= mem[pop_ch][rd_sel];
                out_ch   <= pop_ch;
            end
        end
    end

`ifdef CIRCULAR_BUFFER_MC_ERR_EN
    // A clear of the channel always beats a same-cycle error.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overflow  <= '0;
            underflow <= '0;
        end else begin
            overflow  <= (overflow | (push_sel & full)) & ~clr_hit;
            underflow <= (underflow | (pop_sel & empty)) & ~clr_hit;
        end
    end
`endif

endmodule

// File: tb/tb_circular_buffer_mc.sv
// Directed table plus randomized traffic against a queue-based model.
// Error-flag checks are compiled when CIRCULAR_BUFFER_MC_ERR_EN is defined.
module tb_circular_buffer_mc;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear_en;
    logic [1:0]  clear_ch;
    logic        push_en;
    logic [1:0]  push_ch;
    logic [7:0]  push_data;
    logic        push_ok;
    logic        pop_en;
    logic [1:0]  pop_ch;
    logic        pop_ok;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] count;
    logic [15:0] space;
`ifdef CIRCULAR_BUFFER_MC_ERR_EN
    logic [3:0]  overflow;
    logic [3:0]  underflow;
`endif

    circular_buffer_mc dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_en  (clear_en),
        .clear_ch  (clear_ch),
        .push_en   (push_en),
        .push_ch   (push_ch),
        .push_data (push_data),
        .push_ok   (push_ok),
        .pop_en    (pop_en),
        .pop_ch    (pop_ch),
        .pop_ok    (pop_ok),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .count     (count),
        .space     (space)
`ifdef CIRCULAR_BUFFER_MC_ERR_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       clr_en;
        bit [1:0] clr_ch;
        bit       push_en;
        bit [1:0] push_ch;
        bit [7:0] push_data;
        bit       pop_en;
        bit [1:0] pop_ch;
        bit       exp_push;
        bit       exp_pop;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q [4][$];
    logic [7:0] last_data = 8'h00;
    logic [1:0] last_ch = 2'd0;
`ifdef CIRCULAR_BUFFER_MC_ERR_EN
    bit [3:0] m_ovf = '0;
    bit [3:0] m_unf = '0;
`endif

    vec_t tbl [$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(bit ce, bit [1:0] cc, bit pe, bit [1:0] pc,
                                bit [7:0] pd, bit qe, bit [1:0] qc,
                                bit ep, bit eq);
        vec_t v;
        v.clr_en = ce;   v.clr_ch = cc;
        v.push_en = pe;  v.push_ch = pc; v.push_data = pd;
        v.pop_en = qe;   v.pop_ch = qc;
        v.exp_push = ep; v.exp_pop = eq;
        return v;
    endfunction

    task automatic check_counts();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("count[%0d]", c), 32'(count[c*4 +: 4]), 32'(q[c].size()));
            chk($sformatf("space[%0d]", c), 32'(space[c*4 +: 4]), 32'(8 - q[c].size()));
        end
    endtask

    task automatic step(input vec_t v, input bit use_exp);
        bit pok, qok, pclr, qclr;
        @(negedge clock);
        clear_en  = v.clr_en;
        clear_ch  = v.clr_ch;
        push_en   = v.push_en;
        push_ch   = v.push_ch;
        push_data = v.push_data;
        pop_en    = v.pop_en;
        pop_ch    = v.pop_ch;
        #1;
        pclr = v.clr_en && (v.clr_ch == v.push_ch);
        qclr = v.clr_en && (v.clr_ch == v.pop_ch);
        pok = v.push_en && !pclr && (q[v.push_ch].size() < 8);
        qok = v.pop_en && !qclr && (q[v.pop_ch].size() > 0);
        chk("push_ok", 32'(push_ok), 32'(pok));
        chk("pop_ok", 32'(pop_ok), 32'(qok));
        if (use_exp) begin
            chk("tbl_push_ok", 32'(push_ok), 32'(v.exp_push));
            chk("tbl_pop_ok", 32'(pop_ok), 32'(v.exp_pop));
        end
`ifdef CIRCULAR_BUFFER_MC_ERR_EN
        if (v.push_en && !pclr && q[v.push_ch].size() == 8) m_ovf[v.push_ch] = 1'b1;
        if (v.pop_en && !qclr && q[v.pop_ch].size() == 0) m_unf[v.pop_ch] = 1'b1;
        if (v.clr_en) begin
            m_ovf[v.clr_ch] = 1'b0;
            m_unf[v.clr_ch] = 1'b0;
        end
`endif
        @(posedge clock);
        #1;
        if (qok) begin
            last_data = q[v.pop_ch].pop_front();
            last_ch   = v.pop_ch;
        end
        if (pok) q[v.push_ch].push_back(v.push_data);
        if (v.clr_en) q[v.clr_ch].delete();
        chk("out_valid", 32'(out_valid), 32'(qok));
        chk("out_data", 32'(out_data), 32'(last_data));
        chk("out_ch", 32'(out_ch), 32'(last_ch));
        check_counts();
`ifdef CIRCULAR_BUFFER_MC_ERR_EN
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`endif
    endtask

    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        reset_n = 1'b0;
        clear_en = 0; clear_ch = 0;
        push_en = 0;  push_ch = 0; push_data = 0;
        pop_en = 0;   pop_ch = 0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        check_counts();
        @(negedge clock);
        reset_n = 1'b1;

        // Fill/overfill ch2, then drain/overdrain it.
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 1, 2, 8'(8'h10 + i), 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2, 8'h99, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 2, 0, 0));
        // Wrap-around on ch0.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 1, 0, 8'(8'h20 + i), 0, 0, 1, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 1));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 1, 0, 8'(8'h30 + i), 0, 0, 1, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 1));
        // Simultaneous push+pop on ch1, partly filled then full.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 1, 8'(8'h40 + i), 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h43, 1, 1, 1, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 1, 1, 8'(8'h44 + i), 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h49, 1, 1, 0, 1));
        // Clear ch3 mid-traffic with a push to ch3 and a pop from ch0.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 3, 8'(8'h50 + i), 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h60, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3, 1, 3, 8'h70, 1, 0, 0, 1));

        foreach (tbl[i]) step(tbl[i], 1'b1);
        step(idle, 1'b0);

        // Randomized mixed traffic.
        for (int i = 0; i < 600; i++) begin
            vec_t v;
            v = mk($urandom_range(15) == 0, 2'($urandom), $urandom_range(9) < 6,
                   2'($urandom), 8'($urandom), $urandom_range(9) < 5,
                   2'($urandom), 0, 0);
            step(v, 1'b0);
        end

`ifdef CIRCULAR_BUFFER_MC_ERR_EN
        // Sticky underflow on ch0, then cleared.
        step(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0), 1'b0);
        step(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0), 1'b1);
        chk("underflow0_set", 32'(underflow[0]), 32'd1);
        step(idle, 1'b0);
        chk("underflow0_sticky", 32'(underflow[0]), 32'd1);
        step(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0), 1'b0);
        chk("underflow0_clr", 32'(underflow[0]), 32'd0);
`endif

        // Make sure some channel is non-empty, then reset with a push pending.
        step(mk(0, 0, 1, 2, 8'hA5, 0, 0, 0, 0), 1'b0);
        @(negedge clock);
        reset_n   = 1'b0;
        push_en   = 1'b1;
        push_ch   = 2'd0;
        push_data = 8'h5A;
        pop_en    = 1'b1;
        pop_ch    = 2'd2;
        @(posedge clock);
        #1;
        for (int c = 0; c < 4; c++) q[c].delete();
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_out_data", 32'(out_data), 32'd0);
        chk("rst2_out_ch", 32'(out_ch), 32'd0);
        check_counts();
`ifdef CIRCULAR_BUFFER_MC_ERR_EN
        chk("rst2_overflow", 32'(overflow), 32'd0);
        chk("rst2_underflow", 32'(underflow), 32'd0);
`endif
        @(negedge clock);
        push_en = 1'b0;
        pop_en  = 1'b0;
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
